// File: rtl/output_register_bank_if.sv
// Peripheral bus bundle for output_register_bank.
// The master drives address, strobes and write data. The slave returns read data and the request flag.
interface output_register_bank_if;
    logic        enable;
    logic        peripheralBus_we;
    logic        peripheralBus_oe;
    logic [11:0] peripheralBus_address;
    logic [3:0]  peripheralBus_byteSelect;
    logic [31:0] peripheralBus_dataRead;
    logic [31:0] peripheralBus_dataWrite;
    logic        requestOutput;

    modport master (
        output enable, peripheralBus_we, peripheralBus_oe, peripheralBus_address,
               peripheralBus_byteSelect, peripheralBus_dataWrite,
        input  peripheralBus_dataRead, requestOutput
    );

    modport slave (
        input  enable, peripheralBus_we, peripheralBus_oe, peripheralBus_address,
               peripheralBus_byteSelect, peripheralBus_dataWrite,
        output peripheralBus_dataRead, requestOutput
    );
endinterface

// File: rtl/output_register_bank.sv
// Bank of CHANNELS output registers with set/clear/toggle access and a
// per-channel timed-pulse engine. Each pulse inverts bits for a programmed number of
// cycles and then reverts them.

// One channel: value register, pulse length, and the pulse engine.
module output_register_bank_channel #(
    parameter int          WIDTH                = 32,
    parameter logic [31:0] DEFAULT              = 32'b0,
    parameter logic [15:0] DEFAULT_PULSE_LENGTH = 16'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [4:0]       i_offset,
    input  logic [31:0]      i_mask,
    input  logic [31:0]      i_data,
    output logic [WIDTH-1:0] o_value,
    output logic [WIDTH-1:0] o_pulse_mask,
    output logic [15:0]      o_count,
    output logic [15:0]      o_length,
    output logic             o_busy
);
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] r_pulse_mask;
    logic [15:0]      r_count;
    logic [15:0]      r_length;

    logic [WIDTH-1:0] w_m;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_bus;
    logic             w_start;
    logic             w_expire;
    logic             w_len_wr;

    assign w_m    = i_data[WIDTH-1:0];
    assign w_mask = i_mask[WIDTH-1:0];

    // Register value after the bus operation alone. The pulse XOR is applied on top of it.
    always_comb begin
        w_bus = r_value;
        if (i_we) begin
            case (i_offset)
                5'h00:   w_bus = w_m | (r_value & ~w_mask);
                5'h04:   w_bus = r_value | w_m;
                5'h08:   w_bus = r_value & ~w_m;
                5'h0C:   w_bus = r_value ^ w_m;
                default: w_bus = r_value;
            endcase
        end
    end

    // A zero length or an empty mask never starts a pulse.
    assign w_start  = i_we && (i_offset == 5'h10) && (r_length != 16'd0) && (w_m != '0);
    assign w_expire = (r_state == ST_BUSY) && (r_count == 16'd1);
    assign w_len_wr = i_we && (i_offset == 5'h14);

    // Pulse engine. A retrigger undoes the old mask and applies the new one on the same edge.
    // The pulse mask is zero when idle, so the same formula also covers a fresh start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_value      <= DEFAULT[WIDTH-1:0];
            r_pulse_mask <= '0;
            r_count      <= 16'd0;
            r_length     <= DEFAULT_PULSE_LENGTH;
        end else begin
            if (w_len_wr)
                r_length <= i_data[15:0] | (r_length & ~i_mask[15:0]);
            if (w_start) begin
                r_value      <= w_bus ^ r_pulse_mask ^ w_m;
                r_pulse_mask <= w_m;
                r_count      <= r_length;
                r_state      <= ST_BUSY;
            end else begin
                case (r_state)
                    ST_BUSY: begin
                        if (w_expire) begin
                            r_value      <= w_bus ^ r_pulse_mask;
                            r_pulse_mask <= '0;
                            r_count      <= 16'd0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_value <= w_bus;
                            r_count <= r_count - 16'd1;
                        end
                    end
                    default: r_value <= w_bus;
                endcase
            end
        end
    end

    assign o_value      = r_value;
    assign o_pulse_mask = r_pulse_mask;
    assign o_count      = r_count;
    assign o_length     = r_length;
    assign o_busy       = (r_state == ST_BUSY);
endmodule

// Top level: address decode, channel array, and combinational read mux.
module output_register_bank #(
    parameter int          WIDTH                = 32,
    parameter int          CHANNELS             = 4,
    parameter logic [6:0]  BASE_ADDRESS         = 7'h0,
    parameter logic [31:0] DEFAULT              = 32'b0,
    parameter logic [15:0] DEFAULT_PULSE_LENGTH = 16'd1
) (
    input  logic                       clk,
    input  logic                       rst,
    output_register_bank_if.slave      bus,
    output logic [CHANNELS*WIDTH-1:0]  currentValue,
    output logic [CHANNELS-1:0]        pulseActive
);
    logic [31:0] w_mask;
    logic [31:0] w_m;
    logic [4:0]  w_off;
    logic        w_we_any;
    logic        w_oe_any;
    logic        w_hit;
    logic        w_oe;
    logic [31:0] w_rdata;

    logic [CHANNELS-1:0]            w_sel;
    logic [CHANNELS-1:0][WIDTH-1:0] w_value;
    logic [CHANNELS-1:0][WIDTH-1:0] w_pmask;
    logic [CHANNELS-1:0][15:0]      w_count;
    logic [CHANNELS-1:0][15:0]      w_length;
    logic [CHANNELS-1:0]            w_busy;
    logic [CHANNELS-1:0][31:0]      w_rd;

    assign w_mask = {{8{bus.peripheralBus_byteSelect[3]}}, {8{bus.peripheralBus_byteSelect[2]}},
                     {8{bus.peripheralBus_byteSelect[1]}}, {8{bus.peripheralBus_byteSelect[0]}}};
    assign w_m    = bus.peripheralBus_dataWrite & w_mask;
    assign w_off  = bus.peripheralBus_address[4:0];

    // Asserting both strobes together is treated as no access.
    assign w_we_any = bus.enable & bus.peripheralBus_we & ~bus.peripheralBus_oe;
    assign w_oe_any = bus.enable & bus.peripheralBus_oe & ~bus.peripheralBus_we;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        localparam logic [6:0] CH_ADDR = 7'(BASE_ADDRESS + 7'(g));

        assign w_sel[g] = (bus.peripheralBus_address[11:5] == CH_ADDR);

        output_register_bank_channel #(
            .WIDTH                (WIDTH),
            .DEFAULT              (DEFAULT),
            .DEFAULT_PULSE_LENGTH (DEFAULT_PULSE_LENGTH)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_we         (w_we_any & w_sel[g]),
            .i_offset     (w_off),
            .i_mask       (w_mask),
            .i_data       (w_m),
            .o_value      (w_value[g]),
            .o_pulse_mask (w_pmask[g]),
            .o_count      (w_count[g]),
            .o_length     (w_length[g]),
            .o_busy       (w_busy[g])
        );

        // Per-channel read data by offset. Unused offsets read as zero.
        always_comb begin
            case (w_off)
                5'h00, 5'h04,
                5'h08, 5'h0C: w_rd[g] = 32'(w_value[g]);
                5'h10:        w_rd[g] = 32'(w_pmask[g]);
                5'h14:        w_rd[g] = {16'b0, w_length[g]};
                5'h18:        w_rd[g] = {31'b0, w_busy[g]};
                5'h1C:        w_rd[g] = {16'b0, w_count[g]};
                default:      w_rd[g] = 32'b0;
            endcase
        end
    end

    // Channel selects are one-hot, so an OR-merge acts as the read mux.
    always_comb begin
        w_rdata = 32'b0;
        w_hit   = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_sel[k]) w_rdata = w_rdata | w_rd[k];
            w_hit = w_hit | w_sel[k];
        end
    end

    assign w_oe                       = w_oe_any & w_hit;
    assign bus.requestOutput          = w_oe;
    assign bus.peripheralBus_dataRead = w_oe ? (w_rdata & w_mask) : 32'b0;

    assign currentValue = w_value;
    assign pulseActive  = w_busy;
endmodule

// File: tb/tb_output_register_bank.sv
// Bench for output_register_bank with defaults: WIDTH=32, CHANNELS=4, BASE=0, DEFAULT=0.
// Reads are queued as expectations and retired at the next negedge sample.
module tb_output_register_bank;
    logic        clk;
    logic        rst;
    logic [127:0] currentValue;
    logic [3:0]   pulseActive;

    output_register_bank_if bif();

    output_register_bank dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bif),
        .currentValue (currentValue),
        .pulseActive  (pulseActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_wr;
        int          ch;
        logic [4:0]  off;
        logic [3:0]  be;
        logic [31:0] data;   // write data, or expected read data
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(string nm, bit w, int ch, logic [4:0] off, logic [3:0] be, logic [31:0] d);
        vec_t v;
        v.name = nm; v.is_wr = w; v.ch = ch; v.off = off; v.be = be; v.data = d;
        return v;
    endfunction

    function automatic logic [31:0] cv(int ch);
        return currentValue[ch*32 +: 32];
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bif.enable = 1'b0; bif.peripheralBus_we = 1'b0; bif.peripheralBus_oe = 1'b0;
        bif.peripheralBus_address = 12'h0; bif.peripheralBus_byteSelect = 4'h0;
        bif.peripheralBus_dataWrite = 32'h0;
    endtask

    task automatic drive(int ch, logic [4:0] off, bit we, bit oe, logic [3:0] be, logic [31:0] d);
        bif.enable = 1'b1; bif.peripheralBus_we = we; bif.peripheralBus_oe = oe;
        bif.peripheralBus_address = {7'(ch), off};
        bif.peripheralBus_byteSelect = be; bif.peripheralBus_dataWrite = d;
    endtask

    // One clock: retire a queued read (or confirm silence) at negedge, then move past the posedge.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        checks++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (bif.requestOutput !== 1'b1 || bif.peripheralBus_dataRead !== e.exp) begin
                errors++;
                $display("FAIL %s: got req=%b data=%h, want req=1 data=%h",
                         e.name, bif.requestOutput, bif.peripheralBus_dataRead, e.exp);
            end
        end else if (bif.requestOutput !== 1'b0 || bif.peripheralBus_dataRead !== 32'h0) begin
            errors++;
            $display("FAIL no_response: got req=%b data=%h, want req=0 data=0",
                     bif.requestOutput, bif.peripheralBus_dataRead);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int ch, logic [4:0] off, logic [3:0] be, logic [31:0] d);
        drive(ch, off, 1'b1, 1'b0, be, d);
        tick();
        idle();
    endtask

    task automatic rd(string nm, int ch, logic [4:0] off, logic [3:0] be, logic [31:0] exp);
        sb_t e;
        e.name = nm; e.exp = exp;
        drive(ch, off, 1'b0, 1'b1, be, 32'h0);
        sb.push_back(e);
        tick();
        idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        // Reset reads, then masked set/clear/toggle on channel 1.
        vecs.push_back(mk("rst_ch0_val",  0, 0, 5'h00, 4'hF, 32'h0000_0000));
        vecs.push_back(mk("rst_ch0_len",  0, 0, 5'h14, 4'hF, 32'h0000_0001));
        vecs.push_back(mk("wr",           1, 1, 5'h00, 4'b0011, 32'h1234_5678));
        vecs.push_back(mk("ch1_write",    0, 1, 5'h00, 4'hF, 32'h0000_5678));
        vecs.push_back(mk("set",          1, 1, 5'h04, 4'hF, 32'h00F0_0000));
        vecs.push_back(mk("ch1_set",      0, 1, 5'h04, 4'hF, 32'h00F0_5678));
        vecs.push_back(mk("clr",          1, 1, 5'h08, 4'hF, 32'h0000_0078));
        vecs.push_back(mk("ch1_clear",    0, 1, 5'h08, 4'hF, 32'h00F0_5600));
        vecs.push_back(mk("tog",          1, 1, 5'h0C, 4'b1000, 32'hFFFF_FFFF));
        vecs.push_back(mk("ch1_toggle",   0, 1, 5'h0C, 4'hF, 32'hFFF0_5600));
        vecs.push_back(mk("ch1_lane2",    0, 1, 5'h00, 4'b0100, 32'h00F0_0000));
        vecs.push_back(mk("ro_wr",        1, 1, 5'h18, 4'hF, 32'hFFFF_FFFF));
        vecs.push_back(mk("ro_wr2",       1, 1, 5'h1C, 4'hF, 32'hFFFF_FFFF));
        vecs.push_back(mk("ch1_after_ro", 0, 1, 5'h00, 4'hF, 32'hFFF0_5600));
        vecs.push_back(mk("ch1_busy",     0, 1, 5'h18, 4'hF, 32'h0));
        vecs.push_back(mk("ch1_pmask",    0, 1, 5'h10, 4'hF, 32'h0));
        vecs.push_back(mk("ch1_unused",   0, 1, 5'h1E, 4'hF, 32'h0));

        idle();
        rst = 1'b0;
        #12;
        chk("rst_cv", currentValue[31:0], 32'h0);
        chk("rst_pa", {28'h0, pulseActive}, 32'h0);
        chk("rst_req", {31'h0, bif.requestOutput}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) wr(vecs[i].ch, vecs[i].off, vecs[i].be, vecs[i].data);
            else rd(vecs[i].name, vecs[i].ch, vecs[i].off, vecs[i].be, vecs[i].data);
        end
        chk("ch1_cv", cv(1), 32'hFFF0_5600);

        // Timed pulse on ch0: three cycles high, count reads 3,2,1,0.
        wr(0, 5'h14, 4'hF, 32'd3);
        wr(0, 5'h10, 4'hF, 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pulse_cv_%0d", i), cv(0), (i < 3) ? 32'h1 : 32'h0);
            chk($sformatf("pulse_pa_%0d", i), {31'h0, pulseActive[0]}, (i < 3) ? 32'h1 : 32'h0);
            rd($sformatf("pulse_cnt_%0d", i), 0, 5'h1C, 4'hF, 32'(3 - i));
        end
        chk("pulse_end_cv", cv(0), 32'h0);
        chk("pulse_end_pa", {31'h0, pulseActive[0]}, 32'h0);

        // Retrigger on ch2: 0x1 replaced by 0x2, which then holds five cycles.
        wr(2, 5'h14, 4'hF, 32'd5);
        wr(2, 5'h10, 4'hF, 32'h1);
        chk("retrig_first", cv(2), 32'h1);
        rd("retrig_busy", 2, 5'h18, 4'hF, 32'h1);
        wr(2, 5'h10, 4'hF, 32'h2);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("retrig_cv_%0d", i), cv(2), 32'h2);
            chk($sformatf("retrig_pa_%0d", i), {31'h0, pulseActive[2]}, 32'h1);
            if (i == 0) rd("retrig_pmask", 2, 5'h10, 4'hF, 32'h2);
            else tick();
        end
        chk("retrig_end_cv", cv(2), 32'h0);
        chk("retrig_end_pa", {31'h0, pulseActive[2]}, 32'h0);

        // Collision on ch3: set lands on the expiry edge.
        wr(3, 5'h14, 4'hF, 32'd2);
        wr(3, 5'h10, 4'hF, 32'h4);
        tick();
        wr(3, 5'h04, 4'hF, 32'h1);
        chk("coll_cv", cv(3), 32'h1);
        chk("coll_pa", {31'h0, pulseActive[3]}, 32'h0);
        wr(3, 5'h14, 4'hF, 32'd0);
        wr(3, 5'h10, 4'hF, 32'hF0);
        chk("len0_cv", cv(3), 32'h1);
        chk("len0_pa", {31'h0, pulseActive[3]}, 32'h0);
        wr(3, 5'h14, 4'hF, 32'd4);
        wr(3, 5'h10, 4'h0, 32'hFF);
        chk("m0_pa", {31'h0, pulseActive[3]}, 32'h0);
        // A length write mid-pulse leaves the running count alone.
        wr(3, 5'h10, 4'hF, 32'h2);
        chk("lenbusy_cv", cv(3), 32'h3);
        wr(3, 5'h14, 4'hF, 32'd1);
        rd("lenbusy_cnt", 3, 5'h1C, 4'hF, 32'd3);
        rd("lenbusy_len", 3, 5'h14, 4'hF, 32'd1);
        chk("lenbusy_mid", cv(3), 32'h3);
        tick();
        chk("lenbusy_end", cv(3), 32'h1);

        // Both strobes together, and out-of-range / disabled selects: no response.
        drive(1, 5'h00, 1'b1, 1'b1, 4'hF, 32'h0);
        tick();
        idle();
        chk("weoe_cv", cv(1), 32'hFFF0_5600);
        drive(4, 5'h00, 1'b0, 1'b1, 4'hF, 32'h0);
        tick();
        wr(4, 5'h00, 4'hF, 32'hDEAD_BEEF);
        chk("oob_cv", currentValue[31:0] | currentValue[63:32] | currentValue[95:64] | currentValue[127:96],
            32'hFFF0_5600 | 32'h1);
        drive(0, 5'h14, 1'b0, 1'b1, 4'hF, 32'h0);
        bif.enable = 1'b0;
        tick();
        idle();

        // Asynchronous reset in the middle of a pulse.
        wr(0, 5'h14, 4'hF, 32'd8);
        wr(0, 5'h10, 4'hF, 32'hFF);
        tick();
        chk("pre_rst_cv", cv(0), 32'hFF);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cv", currentValue[31:0] | currentValue[63:32] | currentValue[95:64] | currentValue[127:96], 32'h0);
        chk("arst_pa", {28'h0, pulseActive}, 32'h0);
        rst = 1'b1;
        tick();
        rd("post_rst_len", 0, 5'h14, 4'hF, 32'd1);
        chk("post_rst_cv", cv(0), 32'h0);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/output_register_bank.md
Name: output_register_bank

Overview:
- Parametrised bank of CHANNELS output registers, each WIDTH bits, on the peripheral bus.
- Per channel: write, set, clear and toggle access, with byte-select masking.
- Per channel: a hardware timed-pulse engine that inverts selected bits for a programmable number of clock cycles and then reverts them automatically.
- Drives GPIO-style control lines, strobes and enables for sibling peripherals.

Parameters:
- WIDTH, 32, bits per channel (1..32); read data is zero-padded above WIDTH.
- CHANNELS, 4, number of channels (1..8).
- BASE_ADDRESS, 7'h0, value of peripheralBus_address[11:5] that selects channel 0; channel k is at BASE_ADDRESS+k.
- DEFAULT, 32'b0, reset value of every channel register (low WIDTH bits used).
- DEFAULT_PULSE_LENGTH, 16'd1, reset value of every channel's pulse length.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  bank select from the peripheral decoder.
- peripheralBus_we  input  1  write strobe.
- peripheralBus_oe  input  1  read strobe.
- peripheralBus_address  input  12  byte address.
- peripheralBus_byteSelect  input  4  byte lane enables.
- peripheralBus_dataRead  output  32  read data; 0 when not reading.
- peripheralBus_dataWrite  input  32  write data.
- requestOutput  output  1  high while this block drives a read.
- currentValue  output  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- pulseActive  output  CHANNELS  bit k high while channel k has a pulse in flight.

Behaviour:
- Decode and access strobes:
  - Channel select: enable and address[11:5] == BASE_ADDRESS+k, with k < CHANNELS; otherwise no response.
  - Offset = address[4:0].
  - we = select & peripheralBus_we & !peripheralBus_oe; oe = select & peripheralBus_oe & !peripheralBus_we. When we and oe are both high, neither access happens.
  - mask = byteSelect expanded to 8 bits per lane; M = dataWrite & mask.
- Offset map (W = write effect, R = read data):
  - 0x00 W: reg = M | (reg & ~mask). R: reg.
  - 0x04 W: reg |= M. R: reg.
  - 0x08 W: reg &= ~M. R: reg.
  - 0x0C W: reg ^= M. R: reg.
  - 0x10 W: start pulse with mask M[WIDTH-1:0]. R: active pulse mask, 0 when idle.
  - 0x14 W: pulseLength[15:0] = M | (len & ~mask); upper bits ignored. R: {16'b0, len}.
  - 0x18 R only: {31'b0, busy}.
  - 0x1C R only: {16'b0, count}.
  - Writes to 0x18 and 0x1C are ignored; any unused offset reads 0.
- Read path:
  - Combinational, zero latency.
  - dataRead = oe ? (data & mask) : 0.
  - requestOutput = oe, including on read-only offsets.
- Pulse engine, per channel: state idle/busy, pulseMask[WIDTH-1:0], count[15:0].
  - Pulse write with len == 0 or M == 0: ignored.
  - Pulse write when idle: at that edge reg ^= M, pulseMask = M, count = len, busy = 1.
  - Each following edge while busy: count decrements.
  - The edge where count == 1: reg ^= pulseMask, pulseMask = 0, count = 0, busy = 0.
  - Net effect: bits stay inverted for exactly len cycles. len = 1 gives a one-cycle pulse.
- Pulse retrigger while busy:
  - The old pulse ends immediately and the new one starts.
  - reg = reg ^ oldMask ^ M, pulseMask = M, count = len. No idle cycle in between.
- Simultaneous events in one cycle:
  - Bus write to 0x00–0x0C while busy: the bus result is computed first, then XORed with pulseMask if expiry occurs that same edge. The pulse does not cancel.
  - Writing len while busy: affects only the next pulse; the running count is unchanged.
- pulseActive[k] = busy of channel k.
- Reset (asynchronous, active-low):
  - reg = DEFAULT, len = DEFAULT_PULSE_LENGTH, busy = 0, pulseMask = 0, count = 0.
  - Outputs at reset: dataRead = 0, requestOutput = 0, pulseActive = 0, currentValue = DEFAULT per channel.
  - Reset during a pulse abandons it without revert; reg is forced to DEFAULT.
- Widths: all register operations are truncated to WIDTH; bits above WIDTH are not stored.

Test Plan:
- Reset then read: release rst, read ch0 0x00 with byteSelect=4'hF → 0x00000000, requestOutput=1. Read ch0 0x14 → 0x00000001.
- Masked ops on ch1:
  - Write 0x00 = 0x12345678 with byteSelect=4'b0011 → reg 0x00005678.
  - Set 0x00F00000 with 4'hF → 0x00F05678.
  - Clear 0x00000078 → 0x00F05600.
  - Toggle 0xFFFFFFFF with 4'b1000 → 0xFFF05600.
- Timed pulse on ch0 (reg 0):
  - Write len = 3, then pulse M = 0x1.
  - currentValue[0] = 1 for exactly 3 cycles, then 0.
  - pulseActive[0] high for the same 3 cycles.
  - Reading 0x1C on consecutive cycles returns 3, 2, 1, 0.
- Retrigger: ch2 len = 5, pulse 0x1; two cycles later pulse 0x2 → reg goes 0x1 → 0x2, and 0x2 holds 5 cycles before returning to 0.
- Collision:
  - ch3 len = 2, pulse 0x4; on the expiry cycle, set 0x1 → reg = 0x1 afterwards.
  - Pulse with len = 0 → no change, pulseActive stays 0.
- Async reset mid-pulse, and we+oe together:
  - Drop rst mid-pulse asynchronously → currentValue = DEFAULT and pulseActive = 0 immediately, without waiting for a clock edge.
  - we and oe together → no register change, dataRead = 0, requestOutput = 0.
  - Address with k ≥ CHANNELS → no response.
